// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU decode-and-issue stage: opcodes, funct codes,
// the issue-entry payload and the skid-buffer state encoding.
package alu_issue_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

    localparam logic [2:0] FUNCT3_ADD  = 3'b000;
    localparam logic [2:0] FUNCT3_SLL  = 3'b001;
    localparam logic [2:0] FUNCT3_SLT  = 3'b010;
    localparam logic [2:0] FUNCT3_SLTU = 3'b011;
    localparam logic [2:0] FUNCT3_XOR  = 3'b100;
    localparam logic [2:0] FUNCT3_SR   = 3'b101;
    localparam logic [2:0] FUNCT3_OR   = 3'b110;
    localparam logic [2:0] FUNCT3_AND  = 3'b111;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [XLEN-1:0]   dataa;
        logic [XLEN-1:0]   datab;
        logic [2:0]        funct3;
        logic              sub_sra;
        logic [REG_AW-1:0] rd;
    } issue_entry_t;

    localparam int unsigned ISSUE_W = $bits(issue_entry_t);

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_t;

    function automatic logic [XLEN-1:0] sext_imm12(input logic [11:0] imm);
        return {{(XLEN-12){imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/alu_issue_skid.sv
// Generic two-entry valid/ready skid buffer; the head entry drives the output
// register directly and in_ready is registered from the next state.
module alu_issue_skid
    import alu_issue_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_t  state_q, state_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic         ready_q;
    logic         valid_q;
    logic         push;
    logic         pop;

    assign push = in_valid && ready_q;
    assign pop  = valid_q && out_ready;

    // Next-state and entry movement; flush wins over any push or pop.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            state_d = SKID_EMPTY;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (push) begin
                        state_d = SKID_ONE;
                        head_d  = in_data;
                    end
                end
                SKID_ONE: begin
                    case ({push, pop})
                        2'b10: begin
                            state_d = SKID_TWO;
                            tail_d  = in_data;
                        end
                        2'b11: head_d = in_data;
                        2'b01: state_d = SKID_EMPTY;
                        default: ;
                    endcase
                end
                SKID_TWO: begin
                    if (pop) begin
                        state_d = SKID_ONE;
                        head_d  = tail_q;
                    end
                end
                default: state_d = SKID_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SKID_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            ready_q <= (state_d != SKID_TWO);
            valid_q <= (state_d != SKID_EMPTY);
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign out_data  = head_q;

endmodule

// File: rtl/alu_issue.sv
// RV32I OP/OP-IMM decode-and-issue stage in front of the ALU.
// Define ALU_ISSUE_FWD_EN to enable the writeback bypass onto rs1/rs2.
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_flush,
    input  logic        i_inst_valid,
    output logic        o_inst_ready,
    input  logic [31:0] i_inst,
    output logic [4:0]  o_rs1_addr,
    output logic [4:0]  o_rs2_addr,
    input  logic [31:0] i_rs1_data,
    input  logic [31:0] i_rs2_data,
    input  logic        i_wb_valid,
    input  logic [4:0]  i_wb_rd,
    input  logic [31:0] i_wb_data,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_dataa,
    output logic [31:0] o_datab,
    output logic [2:0]  o_funct3,
    output logic        o_sub_sra,
    output logic [4:0]  o_rd,
    output logic        o_illegal
);

    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    logic          fwd_rs1;
    logic          fwd_rs2;
    logic [31:0]   rs1_val;
    logic [31:0]   rs2_val;
    logic          legal;
    issue_entry_t  dec_entry;
    issue_entry_t  out_entry;
    logic [ISSUE_W-1:0] skid_out;
    logic          accept;
    logic          illegal_q;

    assign opcode     = i_inst[6:0];
    assign funct3     = i_inst[14:12];
    assign funct7     = i_inst[31:25];
    assign o_rs1_addr = i_inst[19:15];
    assign o_rs2_addr = i_inst[24:20];

`ifdef ALU_ISSUE_FWD_EN
    assign fwd_rs1 = i_wb_valid && (i_wb_rd != 5'd0) && (i_wb_rd == o_rs1_addr);
    assign fwd_rs2 = i_wb_valid && (i_wb_rd != 5'd0) && (i_wb_rd == o_rs2_addr);
`else
    logic unused_wb;
    assign unused_wb = ^{i_wb_valid, i_wb_rd, i_wb_data};
    assign fwd_rs1   = 1'b0;
    assign fwd_rs2   = 1'b0;
`endif

    // x0 is hardwired to zero ahead of any bypass.
    assign rs1_val = (o_rs1_addr == 5'd0) ? 32'd0 : (fwd_rs1 ? i_wb_data : i_rs1_data);
    assign rs2_val = (o_rs2_addr == 5'd0) ? 32'd0 : (fwd_rs2 ? i_wb_data : i_rs2_data);

    // Combinational decode into an issue entry plus legality.
    always_comb begin
        legal             = 1'b0;
        dec_entry         = '0;
        dec_entry.dataa   = rs1_val;
        dec_entry.funct3  = funct3;
        dec_entry.rd      = i_inst[11:7];
        case (opcode)
            OPCODE_OP: begin
                dec_entry.datab   = rs2_val;
                dec_entry.sub_sra = i_inst[30];
                legal = (funct7 == FUNCT7_BASE) ||
                        ((funct7 == FUNCT7_ALT) &&
                         ((funct3 == FUNCT3_ADD) || (funct3 == FUNCT3_SR)));
            end
            OPCODE_OP_IMM: begin
                dec_entry.datab = sext_imm12(i_inst[31:20]);
                case (funct3)
                    FUNCT3_SLL: begin
                        dec_entry.datab = {27'd0, i_inst[24:20]};
                        legal = (funct7 == FUNCT7_BASE);
                    end
                    FUNCT3_SR: begin
                        dec_entry.datab   = {27'd0, i_inst[24:20]};
                        dec_entry.sub_sra = i_inst[30];
                        legal = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT);
                    end
                    default: legal = 1'b1;
                endcase
            end
            default: legal = 1'b0;
        endcase
    end

    assign accept = i_inst_valid && o_inst_ready;

    // Illegal pulse follows the consuming edge; suppressed by flush.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= accept && !legal && !i_flush;
        end
    end

    alu_issue_skid #(
        .W (ISSUE_W)
    ) u_skid (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .flush     (i_flush),
        .in_valid  (i_inst_valid && legal),
        .in_ready  (o_inst_ready),
        .in_data   (ISSUE_W'(dec_entry)),
        .out_valid (o_valid),
        .out_ready (i_ready),
        .out_data  (skid_out)
    );

    assign out_entry = issue_entry_t'(skid_out);
    assign o_dataa   = out_entry.dataa;
    assign o_datab   = out_entry.datab;
    assign o_funct3  = out_entry.funct3;
    assign o_sub_sra = out_entry.sub_sra;
    assign o_rd      = out_entry.rd;
    assign o_illegal = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: expected entries queued on accept and
// compared when the stage hands an operation to execute.
module tb_alu_issue;
    import alu_issue_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_flush;
    logic        i_inst_valid;
    logic        o_inst_ready;
    logic [31:0] i_inst;
    logic [4:0]  o_rs1_addr;
    logic [4:0]  o_rs2_addr;
    logic [31:0] i_rs1_data;
    logic [31:0] i_rs2_data;
    logic        i_wb_valid;
    logic [4:0]  i_wb_rd;
    logic [31:0] i_wb_data;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_dataa;
    logic [31:0] o_datab;
    logic [2:0]  o_funct3;
    logic        o_sub_sra;
    logic [4:0]  o_rd;
    logic        o_illegal;

    alu_issue dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_flush      (i_flush),
        .i_inst_valid (i_inst_valid),
        .o_inst_ready (o_inst_ready),
        .i_inst       (i_inst),
        .o_rs1_addr   (o_rs1_addr),
        .o_rs2_addr   (o_rs2_addr),
        .i_rs1_data   (i_rs1_data),
        .i_rs2_data   (i_rs2_data),
        .i_wb_valid   (i_wb_valid),
        .i_wb_rd      (i_wb_rd),
        .i_wb_data    (i_wb_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_dataa      (o_dataa),
        .o_datab      (o_datab),
        .o_funct3     (o_funct3),
        .o_sub_sra    (o_sub_sra),
        .o_rd         (o_rd),
        .o_illegal    (o_illegal)
    );

    always #5 i_clk = ~i_clk;

    issue_entry_t sb[$];
    int n_vec = 0;
    int n_err = 0;
    int ill_cnt = 0;
    int ticks = 0;
    bit rand_ready = 1'b0;

    function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_ins(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic issue_entry_t mk(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] f3, input logic s,
                                        input logic [4:0] rd);
        issue_entry_t e;
        e.dataa = a; e.datab = b; e.funct3 = f3; e.sub_sra = s; e.rd = rd;
        return e;
    endfunction

    // One clock: scoreboard check at the falling edge, then step past the rising edge.
    task automatic tick();
        issue_entry_t exp_e;
        issue_entry_t act_e;
        @(negedge i_clk);
        if (o_illegal) ill_cnt++;
        if (o_valid && i_ready) begin
            act_e = mk(o_dataa, o_datab, o_funct3, o_sub_sra, o_rd);
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got %h, required no output", act_e);
            end else begin
                exp_e = sb.pop_front();
                if (act_e !== exp_e) begin
                    n_err++;
                    $display("FAIL sb_entry: got a=%h b=%h f3=%b s=%b rd=%0d, required a=%h b=%h f3=%b s=%b rd=%0d",
                             act_e.dataa, act_e.datab, act_e.funct3, act_e.sub_sra, act_e.rd,
                             exp_e.dataa, exp_e.datab, exp_e.funct3, exp_e.sub_sra, exp_e.rd);
                end
            end
        end
        @(posedge i_clk);
        #1;
        ticks++;
        if (rand_ready) i_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [31:0] inst, input logic [31:0] r1, input logic [31:0] r2,
                        input issue_entry_t e, input bit legal);
        bit acc;
        acc = 1'b0;
        i_inst = inst; i_rs1_data = r1; i_rs2_data = r2; i_inst_valid = 1'b1;
        for (int k = 0; k < 64 && !acc; k++) begin
            acc = o_inst_ready;
            if (acc && legal) sb.push_back(e);
            tick();
        end
        n_vec++;
        if (!acc) begin
            n_err++;
            $display("FAIL send_timeout: inst %h not accepted, required accept within 64 cycles", inst);
        end
        i_inst_valid = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_flush = 1'b0; i_inst_valid = 1'b0; i_inst = '0;
        i_rs1_data = '0; i_rs2_data = '0; i_wb_valid = 1'b0; i_wb_rd = '0;
        i_wb_data = '0; i_ready = 1'b1;
        repeat (3) @(posedge i_clk);
        #3 i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_inst_ready", 32'(o_inst_ready), 32'd1);
        chk("rst_illegal", 32'(o_illegal), 32'd0);
        chk("rst_dataa", o_dataa, 32'd0);
        chk("rst_datab", o_datab, 32'd0);
        chk("rst_f3_s_rd", {23'd0, o_funct3, o_sub_sra, o_rd}, 32'd0);
    endtask

    task automatic test_add();
        i_ready = 1'b1;
        send(r_ins(FUNCT7_BASE, 5'd2, 5'd1, FUNCT3_ADD, 5'd3), 32'd5, 32'd7,
             mk(32'd5, 32'd7, FUNCT3_ADD, 1'b0, 5'd3), 1'b1);
        chk("add_latency_valid", 32'(o_valid), 32'd1);
        chk("add_rs_addr", {22'd0, o_rs1_addr, o_rs2_addr}, {22'd0, 5'd1, 5'd2});
        drain(2);
    endtask

    task automatic test_decode();
        i_ready = 1'b1;
        send(i_ins(12'hFFF, 5'd0, FUNCT3_ADD, 5'd4), 32'h1234, 32'h5678,
             mk(32'd0, 32'hFFFF_FFFF, FUNCT3_ADD, 1'b0, 5'd4), 1'b1);
        send(i_ins({FUNCT7_ALT, 5'd31}, 5'd6, FUNCT3_SR, 5'd5), 32'h8000_0000, 32'h1,
             mk(32'h8000_0000, 32'd31, FUNCT3_SR, 1'b1, 5'd5), 1'b1);
        send(i_ins({FUNCT7_BASE, 5'd3}, 5'd10, FUNCT3_SR, 5'd9), 32'hF0, 32'h0,
             mk(32'hF0, 32'd3, FUNCT3_SR, 1'b0, 5'd9), 1'b1);
        send(i_ins({FUNCT7_BASE, 5'd4}, 5'd2, FUNCT3_SLL, 5'd1), 32'h11, 32'h0,
             mk(32'h11, 32'd4, FUNCT3_SLL, 1'b0, 5'd1), 1'b1);
        send(i_ins(12'h800, 5'd8, FUNCT3_SLT, 5'd7), 32'h42, 32'h0,
             mk(32'h42, 32'hFFFF_F800, FUNCT3_SLT, 1'b0, 5'd7), 1'b1);
        send(i_ins(12'h400, 5'd12, FUNCT3_OR, 5'd11), 32'h3, 32'h0,
             mk(32'h3, 32'h0000_0400, FUNCT3_OR, 1'b0, 5'd11), 1'b1);
        send(i_ins(12'h7FF, 5'd14, FUNCT3_XOR, 5'd31), 32'hA5A5, 32'h0,
             mk(32'hA5A5, 32'h0000_07FF, FUNCT3_XOR, 1'b0, 5'd31), 1'b1);
        send(r_ins(FUNCT7_ALT, 5'd15, 5'd14, FUNCT3_ADD, 5'd13), 32'd100, 32'd1,
             mk(32'd100, 32'd1, FUNCT3_ADD, 1'b1, 5'd13), 1'b1);
        send(r_ins(FUNCT7_ALT, 5'd17, 5'd16, FUNCT3_SR, 5'd18), 32'hDEAD_0000, 32'd8,
             mk(32'hDEAD_0000, 32'd8, FUNCT3_SR, 1'b1, 5'd18), 1'b1);
        send(r_ins(FUNCT7_BASE, 5'd0, 5'd20, FUNCT3_SLTU, 5'd21), 32'h7, 32'h99,
             mk(32'h7, 32'd0, FUNCT3_SLTU, 1'b0, 5'd21), 1'b1);
        send(r_ins(FUNCT7_BASE, 5'd22, 5'd23, FUNCT3_AND, 5'd24), 32'hFF00, 32'h0FF0,
             mk(32'hFF00, 32'h0FF0, FUNCT3_AND, 1'b0, 5'd24), 1'b1);
        drain(2);
    endtask

    task automatic test_backpressure();
        i_ready = 1'b0;
        send(r_ins(FUNCT7_BASE, 5'd2, 5'd1, FUNCT3_ADD, 5'd3), 32'hA, 32'hB,
             mk(32'hA, 32'hB, FUNCT3_ADD, 1'b0, 5'd3), 1'b1);
        send(r_ins(FUNCT7_BASE, 5'd5, 5'd4, FUNCT3_XOR, 5'd6), 32'hC, 32'hD,
             mk(32'hC, 32'hD, FUNCT3_XOR, 1'b0, 5'd6), 1'b1);
        chk("bp_inst_ready_full", 32'(o_inst_ready), 32'd0);
        tick(); tick();
        chk("bp_hold_valid", 32'(o_valid), 32'd1);
        chk("bp_hold_dataa", o_dataa, 32'hA);
        chk("bp_hold_rd", 32'(o_rd), 32'd3);
        i_ready = 1'b1;
        send(r_ins(FUNCT7_BASE, 5'd8, 5'd7, FUNCT3_OR, 5'd9), 32'hE, 32'hF,
             mk(32'hE, 32'hF, FUNCT3_OR, 1'b0, 5'd9), 1'b1);
        drain(3);
    endtask

    task automatic test_illegal();
        int base;
        i_ready = 1'b1;
        base = ill_cnt;
        send({12'h004, 5'd1, 3'b010, 5'd2, 7'b0000011}, 32'h1, 32'h2, mk(0, 0, 0, 0, 0), 1'b0);
        chk("ill_load_pulse", 32'(o_illegal), 32'd1);
        chk("ill_load_novalid", 32'(o_valid), 32'd0);
        tick();
        chk("ill_load_clear", 32'(o_illegal), 32'd0);
        send(r_ins(FUNCT7_ALT, 5'd2, 5'd1, FUNCT3_AND, 5'd3), 32'h1, 32'h2, mk(0, 0, 0, 0, 0), 1'b0);
        chk("ill_suband_pulse", 32'(o_illegal), 32'd1);
        chk("ill_suband_novalid", 32'(o_valid), 32'd0);
        send(i_ins({FUNCT7_ALT, 5'd1}, 5'd1, FUNCT3_SLL, 5'd3), 32'h1, 32'h2, mk(0, 0, 0, 0, 0), 1'b0);
        send(i_ins({7'b0000001, 5'd1}, 5'd1, FUNCT3_SR, 5'd3), 32'h1, 32'h2, mk(0, 0, 0, 0, 0), 1'b0);
        tick(); tick();
        chk("ill_pulse_count", 32'(ill_cnt - base), 32'd4);
        chk("ill_sb_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic test_back_to_back();
        int t0;
        i_ready = 1'b1;
        t0 = ticks;
        for (int k = 1; k <= 6; k++) begin
            send(r_ins(FUNCT7_BASE, 5'(k + 8), 5'(k), FUNCT3_ADD, 5'(k + 16)),
                 32'(k * 3), 32'(k * 5),
                 mk(32'(k * 3), 32'(k * 5), FUNCT3_ADD, 1'b0, 5'(k + 16)), 1'b1);
        end
        chk("b2b_cycles", 32'(ticks - t0), 32'd6);
        drain(2);
        rand_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            logic [4:0] a1, a2, rd;
            logic [31:0] d1, d2;
            logic s;
            a1 = 5'($urandom_range(1, 31)); a2 = 5'($urandom_range(1, 31));
            rd = 5'($urandom_range(0, 31)); d1 = $urandom; d2 = $urandom;
            s = 1'($urandom_range(0, 1));
            send(r_ins(s ? FUNCT7_ALT : FUNCT7_BASE, a2, a1, FUNCT3_ADD, rd), d1, d2,
                 mk(d1, d2, FUNCT3_ADD, s, rd), 1'b1);
        end
        rand_ready = 1'b0;
        i_ready = 1'b1;
        drain(4);
    endtask

    task automatic test_flush();
        i_ready = 1'b0;
        send(r_ins(FUNCT7_BASE, 5'd2, 5'd1, FUNCT3_ADD, 5'd3), 32'h1, 32'h2,
             mk(32'h1, 32'h2, FUNCT3_ADD, 1'b0, 5'd3), 1'b1);
        send(r_ins(FUNCT7_BASE, 5'd2, 5'd1, FUNCT3_ADD, 5'd4), 32'h3, 32'h4,
             mk(32'h3, 32'h4, FUNCT3_ADD, 1'b0, 5'd4), 1'b1);
        i_inst = r_ins(FUNCT7_BASE, 5'd2, 5'd1, FUNCT3_ADD, 5'd5);
        i_inst_valid = 1'b1; i_flush = 1'b1;
        tick();
        i_inst_valid = 1'b0; i_flush = 1'b0;
        sb.delete();
        chk("flush_two_valid", 32'(o_valid), 32'd0);
        chk("flush_two_ready", 32'(o_inst_ready), 32'd1);
        i_inst = r_ins(FUNCT7_BASE, 5'd2, 5'd1, FUNCT3_ADD, 5'd6);
        i_inst_valid = 1'b1; i_flush = 1'b1;
        tick();
        chk("flush_accept_discard", 32'(o_valid), 32'd0);
        i_inst = {12'h0, 5'd1, 3'b000, 5'd2, 7'b0000011};
        tick();
        i_inst_valid = 1'b0; i_flush = 1'b0;
        chk("flush_illegal_masked", 32'(o_illegal), 32'd0);
        i_ready = 1'b1;
        drain(2);
    endtask

    task automatic test_async_reset();
        i_ready = 1'b0;
        send(r_ins(FUNCT7_BASE, 5'd2, 5'd1, FUNCT3_ADD, 5'd3), 32'h1, 32'h2,
             mk(32'h1, 32'h2, FUNCT3_ADD, 1'b0, 5'd3), 1'b1);
        send(r_ins(FUNCT7_BASE, 5'd2, 5'd1, FUNCT3_ADD, 5'd4), 32'h3, 32'h4,
             mk(32'h3, 32'h4, FUNCT3_ADD, 1'b0, 5'd4), 1'b1);
        #2 i_rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(o_valid), 32'd0);
        chk("arst_ready", 32'(o_inst_ready), 32'd1);
        sb.delete();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b1;
        drain(2);
    endtask

    task automatic test_fwd();
        i_ready = 1'b1;
        i_wb_valid = 1'b1; i_wb_rd = 5'd1; i_wb_data = 32'hDEAD_BEEF;
`ifdef ALU_ISSUE_FWD_EN
        send(r_ins(FUNCT7_BASE, 5'd1, 5'd1, FUNCT3_ADD, 5'd2), 32'd0, 32'd0,
             mk(32'hDEAD_BEEF, 32'hDEAD_BEEF, FUNCT3_ADD, 1'b0, 5'd2), 1'b1);
        send(i_ins(12'h010, 5'd1, FUNCT3_ADD, 5'd2), 32'd0, 32'd0,
             mk(32'hDEAD_BEEF, 32'h10, FUNCT3_ADD, 1'b0, 5'd2), 1'b1);
`else
        send(r_ins(FUNCT7_BASE, 5'd1, 5'd1, FUNCT3_ADD, 5'd2), 32'd0, 32'd0,
             mk(32'd0, 32'd0, FUNCT3_ADD, 1'b0, 5'd2), 1'b1);
        send(i_ins(12'h010, 5'd1, FUNCT3_ADD, 5'd2), 32'd0, 32'd0,
             mk(32'd0, 32'h10, FUNCT3_ADD, 1'b0, 5'd2), 1'b1);
`endif
        i_wb_rd = 5'd0;
        send(r_ins(FUNCT7_BASE, 5'd0, 5'd0, FUNCT3_ADD, 5'd2), 32'h55, 32'h66,
             mk(32'd0, 32'd0, FUNCT3_ADD, 1'b0, 5'd2), 1'b1);
        i_wb_valid = 1'b0;
        drain(2);
    endtask

    initial begin
        test_reset();
        test_add();
        test_decode();
        test_backpressure();
        test_illegal();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_fwd();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Decode-and-issue stage that sits directly upstream of the register-to-register ALU. It accepts 32-bit RV32I OP and OP-IMM instructions over a valid/ready handshake and reads rs1/rs2 from the register file. It generates the immediate and drives the ALU operand bus (dataa, datab, funct3, sub_sra) plus the destination register. Output is registered and backed by a two-entry skid buffer, so back-pressure from execute never creates a combinational ready path.

## Interface
- Parameters: none.
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_flush  in  1  synchronous pipeline flush.
- i_inst_valid  in  1  instruction valid.
- o_inst_ready  out  1  stage can accept; registered.
- i_inst  in  32  instruction word.
- o_rs1_addr  out  5  regfile read address, inst[19:15]; combinational from i_inst.
- o_rs2_addr  out  5  regfile read address, inst[24:20]; combinational from i_inst.
- i_rs1_data  in  32  regfile read data, valid in the same cycle.
- i_rs2_data  in  32  regfile read data, valid in the same cycle.
- i_wb_valid  in  1  writeback bypass valid (ALU_ISSUE_FWD_EN only).
- i_wb_rd  in  5  writeback bypass destination (ALU_ISSUE_FWD_EN only).
- i_wb_data  in  32  writeback bypass data (ALU_ISSUE_FWD_EN only).
- o_valid  out  1  issued operation valid.
- i_ready  in  1  ALU/execute accepts.
- o_dataa  out  32  operand A (rs1 value).
- o_datab  out  32  operand B (rs2 value or sign-extended immediate).
- o_funct3  out  3  ALU operation code.
- o_sub_sra  out  1  SUB/SRA modifier.
- o_rd  out  5  destination register.
- o_illegal  out  1  one-cycle pulse when an unsupported instruction is consumed.

## Operation
- Accept: i_inst_valid && o_inst_ready on a clock edge.
- OP, opcode 0110011:
  - datab = rs2 value.
  - sub_sra = inst[30].
  - Legal only if funct7 = 0000000, or funct7 = 0100000 with funct3 ∈ {000, 101}.
- OP-IMM, opcode 0010011:
  - datab = sign-extended inst[31:20].
  - Shifts (funct3 001/101): datab = {27'b0, inst[24:20]}.
  - sub_sra = inst[30] only for funct3 101; otherwise 0.
  - SLLI requires funct7 = 0000000.
  - SRLI/SRAI require funct7 ∈ {0000000, 0100000}.
- funct3 codes: 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SR, 110 OR, 111 AND.
- Register x0 reads as 0 regardless of i_rs*_data.
- Any other opcode, or an illegal funct7, is consumed without producing an entry; o_illegal pulses in the following cycle.
- Buffer state machine: EMPTY → ONE → TWO.
  - Accept without drain: advance one state.
  - Drain (o_valid && i_ready) without accept: retreat one state.
  - Accept and drain in the same cycle: state unchanged.
  - Entries leave in FIFO order.
- o_inst_ready = (state != TWO), registered.
- i_flush: state → EMPTY and o_illegal → 0 next cycle; any instruction accepted in the flush cycle is discarded.
- Buffered operands are not updated after capture. RAW hazards against in-flight entries are resolved by the hazard unit upstream.

## Timing
- Latency: accept at edge N → o_valid high after edge N.
- Throughput: one instruction per cycle while i_ready = 1.
- o_valid and the output payload stay stable while o_valid && !i_ready.
- Reset values:
  - o_valid = 0, o_inst_ready = 1, o_illegal = 0.
  - o_dataa = o_datab = 0, o_funct3 = 0, o_sub_sra = 0, o_rd = 0.
  - State = EMPTY.
- Reset asserted mid-operation drops all entries immediately (asynchronous).
- In state TWO, one drain cycle re-raises o_inst_ready on the next edge.

## Configuration
- ALU_ISSUE_FWD_EN defined:
  - When i_wb_valid && i_wb_rd != 0 && i_wb_rd == rsX address in the accept cycle, the operand uses i_wb_data instead of i_rsX_data.
  - Applies to rs1 and rs2 independently.
  - For OP-IMM, forwarding applies to rs1 only.
- Macro undefined: the i_wb_* ports exist but are ignored.

## Structure
- Shared defines package holds:
  - Opcode constants OPCODE_OP and OPCODE_OP_IMM.
  - FUNCT3_* codes matching the ALU.
  - FUNCT7_BASE and FUNCT7_ALT.
  - The issue-entry struct/width: dataa, datab, funct3, sub_sra, rd = 73 bits.
- Sub-module alu_issue_skid: a generic two-entry valid/ready skid buffer parameterised on payload width. The decoder is a combinational front end feeding it.

## Test plan
- Reset, then ADD x3,x1,x2 with rs1 = 5, rs2 = 7, i_ready = 1 -> next cycle o_valid = 1, dataa = 5, datab = 7, funct3 = 000, sub_sra = 0, rd = 3.
- ADDI x4,x0,-1 -> dataa = 0, datab = 0xFFFFFFFF, sub_sra = 0 (inst[30] set by the immediate, ignored). SRAI x5,x6,31 -> datab = 31, sub_sra = 1.
- i_ready held 0 while 3 instructions are offered -> two captured, o_inst_ready = 0; then release -> outputs in order, no loss or duplication.
- Opcode 0000011, or OP with funct7 = 0100000 and funct3 = 111 -> o_illegal pulses once, o_valid stays 0.
- i_flush in state TWO with a simultaneous accept -> next cycle o_valid = 0, o_inst_ready = 1.
- ALU_ISSUE_FWD_EN: wb_rd = 1, wb_data = 0xDEADBEEF, i_rs1_data = 0 for ADD x2,x1,x1 -> dataa = datab = 0xDEADBEEF. With wb_rd = 0 -> operands = 0.
